// File: rtl/secret_accum_arb.sv
// Round-robin arbiter/sequencer sharing one gated-clock accumulator among NREQ requesters.
// Optional macro SECRET_ARB_PRIO_EN: requester 0 takes strict priority over the rotation.
module secret_accum_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [31:0]          rsp_data,
    output logic [31:0]          accum_in,
    output logic                 clk_en,
    input  logic [31:0]          accum_out,
    output logic [CNT_W-1:0]     txn_count,
    output logic                 busy
);
    localparam int unsigned DW    = 32;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned SEL_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] lat_id;

    logic [DW-1:0]    data_arr [NREQ];
    logic             win_found;
    logic [SEL_W-1:0] win_sel;
    logic [SEL_W-1:0] cand_sel;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  next_ptr;
    logic [DW-1:0]    win_data;
    int unsigned      cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign data_arr[g] = req_data[g*DW +: DW];
    end

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_sel   = '0;
        cand      = 0;
        cand_sel  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand     = (32'(rr_ptr) + k) % NREQ;
            cand_sel = SEL_W'(cand);
            if (!win_found && req_valid[cand_sel]) begin
                win_found = 1'b1;
                win_sel   = cand_sel;
            end
        end
`ifdef SECRET_ARB_PRIO_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_sel   = '0;
        end
`endif
    end

    always_comb begin
        win_id   = ID_W'(win_sel);
        win_data = data_arr[win_sel];
        next_ptr = ((32'(win_id) + 32'd1) >= NREQ) ? '0 : win_id + ID_W'(1);
`ifdef SECRET_ARB_PRIO_EN
        // A requester-0 win does not disturb the rotation among the others
        if (win_id == '0) begin
            next_ptr = rr_ptr;
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found) begin
            req_ready[win_sel] = 1'b1;
        end
    end

    // Sequencer: grant, one enabled accumulator edge, capture, respond
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lat_id    <= '0;
            clk_en    <= 1'b0;
            accum_in  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            txn_count <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        lat_id   <= win_id;
                        rr_ptr   <= next_ptr;
                        clk_en   <= 1'b1;
                        accum_in <= win_data;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    clk_en   <= 1'b0;
                    accum_in <= '0;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data  <= accum_out;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + CNT_W'(1);
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
